// File: rtl/alu_pkg.sv
// Shared ALU definitions: right-shifter FSM states, default widths and the
// shift-type encoding also used by the ALU control decoder.
package alu_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } shr_state_t;

   localparam int SHR_WIDTH   = 32;
   localparam int SHR_SHAMT_W = 5;

   localparam logic SHR_LOGICAL = 1'b0;
   localparam logic SHR_ARITH   = 1'b1;

endpackage

// File: rtl/shr_step.sv
// Single-cycle shift network: moves data right by k (0..STEP) bits and
// fills the vacated top bits with the fill bit.
module shr_step #(
   parameter int WIDTH = 32,
   parameter int K_W   = 1
) (
   input  logic [WIDTH-1:0] data,
   input  logic             fill,
   input  logic [K_W-1:0]   k,
   output logic [WIDTH-1:0] result
);

   // The fill bit becomes the sign of a one-bit-wider word, so an
   // arithmetic shift replicates it into every vacated position.
   logic signed [WIDTH:0] ext;

   assign ext    = {fill, data};
   assign result = WIDTH'(ext >>> k);

endmodule

// File: rtl/shift_right_iter.sv
// Iterative right shifter (SRL/SRA/SRLV/SRAV): accepts one operand, shifts
// at most STEP bits per clock, then holds the result until it is taken.
module shift_right_iter
   import alu_pkg::*;
#(
   parameter int WIDTH   = SHR_WIDTH,
   parameter int SHAMT_W = SHR_SHAMT_W,
   parameter int STEP    = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               arith,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   y,
   output logic               busy
);

   localparam int K_W = $clog2(STEP + 1);

   shr_state_t         state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               fill_q, fill_d;
   logic [K_W-1:0]     k;
   logic [WIDTH-1:0]   step_out;

   // Never shift past the remaining count, so cnt cannot underflow.
   always_comb begin
      if (int'(cnt_q) > STEP) begin
         k = K_W'(STEP);
      end else begin
         k = K_W'(cnt_q);
      end
   end

   shr_step #(
      .WIDTH (WIDTH),
      .K_W   (K_W)
   ) u_step (
      .data   (data_q),
      .fill   (fill_q),
      .k      (k),
      .result (step_out)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      fill_d  = fill_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               data_d  = a;
               cnt_d   = shamt;
               fill_d  = (arith == SHR_ARITH) & a[WIDTH-1];
               state_d = (shamt == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            data_d = step_out;
            cnt_d  = cnt_q - SHAMT_W'(k);
            if (cnt_d == '0) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         fill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
      end
   end

   // y is forced to zero outside DONE so nothing leaks onto the bypass mux.
   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign y         = out_valid ? data_q : '0;

endmodule

// File: tb/tb_shift_right_iter.sv
// Self-checking bench for shift_right_iter: a STEP=1 and a STEP=4 instance,
// expected results queued at request time and compared at the result handshake.
module tb_shift_right_iter;

   logic        clk;
   logic        reset_n;
   logic [31:0] a;
   logic [4:0]  shamt;
   logic        arith;

   logic        inValid1, inReady1, outValid1, outReady1, busy1;
   logic [31:0] y1;
   logic        inValid4, inReady4, outValid4, outReady4, busy4;
   logic [31:0] y4;

   int vectorCount;
   int miscompareCount;
   logic [31:0] expQ[$];

   shift_right_iter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (inValid1),
      .in_ready  (inReady1),
      .a         (a),
      .shamt     (shamt),
      .arith     (arith),
      .out_valid (outValid1),
      .out_ready (outReady1),
      .y         (y1),
      .busy      (busy1)
   );

   shift_right_iter #(.STEP(4)) dut4 (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (inValid4),
      .in_ready  (inReady4),
      .a         (a),
      .shamt     (shamt),
      .arith     (arith),
      .out_valid (outValid4),
      .out_ready (outReady4),
      .y         (y4),
      .busy      (busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         miscompareCount++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Bit-by-bit reference: result bit i comes from operand bit i+s, or fill.
   function automatic logic [31:0] refShr(input logic [31:0] v, input logic [4:0] s, input logic ar);
      logic [31:0] r;
      int src;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         src = i + int'(s);
         r[i] = (src < 32) ? v[5'(src)] : (ar & v[31]);
      end
      return r;
   endfunction

   function automatic logic curValid(input bit sel);
      return sel ? outValid4 : outValid1;
   endfunction
   function automatic logic curReady(input bit sel);
      return sel ? inReady4 : inReady1;
   endfunction
   function automatic logic curBusy(input bit sel);
      return sel ? busy4 : busy1;
   endfunction
   function automatic logic [31:0] curY(input bit sel);
      return sel ? y4 : y1;
   endfunction

   task automatic setInValid(input bit sel, input logic v);
      if (sel) inValid4 = v; else inValid1 = v;
   endtask
   task automatic setOutReady(input bit sel, input logic v);
      if (sel) outReady4 = v; else outReady1 = v;
   endtask

   // One full transaction; holdCycles > 0 stalls the consumer after out_valid.
   task automatic applyStimulus(input bit sel, input logic [31:0] aIn, input logic [4:0] shamtIn,
                                input logic arithIn, input logic [31:0] expY, input int holdCycles);
      int step, expLat, lat;
      step   = sel ? 4 : 1;
      expLat = (int'(shamtIn) + step - 1) / step;
      @(negedge clk);
      a     = aIn;
      shamt = shamtIn;
      arith = arithIn;
      setInValid(sel, 1'b1);
      setOutReady(sel, holdCycles == 0);
      checkOutput("in_ready_idle", 32'(curReady(sel)), 32'd1);
      expQ.push_back(expY);
      @(posedge clk);
      @(negedge clk);
      setInValid(sel, 1'b0);
      lat = 0;
      while (!curValid(sel) && lat < 100) begin
         checkOutput("busy_shift", 32'(curBusy(sel)), 32'd1);
         checkOutput("y_zero_shift", curY(sel), 32'd0);
         @(negedge clk);
         lat++;
      end
      if (!curValid(sel)) begin
         checkOutput("timeout_out_valid", 32'(curValid(sel)), 32'd1);
         void'(expQ.pop_front());
         return;
      end
      checkOutput("latency", 32'(lat), 32'(expLat));
      for (int i = 0; i < holdCycles; i++) begin
         setInValid(sel, (i % 2) == 0);
         checkOutput("y_hold", curY(sel), expQ[0]);
         checkOutput("in_ready_hold", 32'(curReady(sel)), 32'd0);
         checkOutput("out_valid_hold", 32'(curValid(sel)), 32'd1);
         @(negedge clk);
      end
      setInValid(sel, 1'b0);
      setOutReady(sel, 1'b1);
      checkOutput("out_valid_done", 32'(curValid(sel)), 32'd1);
      checkOutput("busy_done", 32'(curBusy(sel)), 32'd1);
      checkOutput("y_result", curY(sel), expQ.pop_front());
      @(negedge clk);
      checkOutput("out_valid_drop", 32'(curValid(sel)), 32'd0);
      checkOutput("y_zero_after", curY(sel), 32'd0);
      checkOutput("in_ready_after", 32'(curReady(sel)), 32'd1);
      checkOutput("busy_after", 32'(curBusy(sel)), 32'd0);
   endtask

   initial begin
      logic [31:0] ra;
      logic [4:0]  rs;
      logic        rar;
      vectorCount     = 0;
      miscompareCount = 0;
      reset_n   = 1'b0;
      inValid1  = 1'b0;
      inValid4  = 1'b0;
      outReady1 = 1'b0;
      outReady4 = 1'b0;
      a         = '0;
      shamt     = '0;
      arith     = 1'b0;

      repeat (2) @(negedge clk);
      checkOutput("rst_in_ready", 32'(inReady1), 32'd1);
      checkOutput("rst_out_valid", 32'(outValid1), 32'd0);
      checkOutput("rst_y", y1, 32'd0);
      checkOutput("rst_busy", 32'(busy1), 32'd0);
      checkOutput("rst_busy4", 32'(busy4), 32'd0);
      reset_n = 1'b1;

      // out_ready while idle must not produce anything
      outReady1 = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("idle_out_valid", 32'(outValid1), 32'd0);
      checkOutput("idle_in_ready", 32'(inReady1), 32'd1);
      outReady1 = 1'b0;

      // Reset in the middle of a 20-bit shift
      a = 32'hFFFF_0000; shamt = 5'd20; arith = 1'b0; inValid1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      inValid1 = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("mid_busy", 32'(busy1), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("mid_rst_in_ready", 32'(inReady1), 32'd1);
      checkOutput("mid_rst_out_valid", 32'(outValid1), 32'd0);
      checkOutput("mid_rst_y", y1, 32'd0);
      checkOutput("mid_rst_busy", 32'(busy1), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("post_rst_no_result", 32'(outValid1), 32'd0);
      applyStimulus(1'b0, 32'hFFFF_0000, 5'd20, 1'b0, 32'h0000_0FFF, 0);

      applyStimulus(1'b0, 32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000, 0);
      applyStimulus(1'b0, 32'h8000_00F0, 5'd31, 1'b1, 32'hFFFF_FFFF, 0);
      applyStimulus(1'b0, 32'h8000_00F0, 5'd31, 1'b0, 32'h0000_0001, 0);
      applyStimulus(1'b0, 32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678, 0);
      applyStimulus(1'b0, 32'h0000_0F00, 5'd8,  1'b0, 32'h0000_000F, 5);

      applyStimulus(1'b1, 32'hF000_0000, 5'd10, 1'b1, 32'hFFFC_0000, 0);
      applyStimulus(1'b1, 32'h8000_00F0, 5'd31, 1'b1, 32'hFFFF_FFFF, 2);
      applyStimulus(1'b1, 32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 0);

      for (int n = 0; n < 12; n++) begin
         ra  = $urandom;
         rs  = 5'($urandom_range(0, 31));
         rar = 1'($urandom_range(0, 1));
         applyStimulus(1'(n % 2), ra, rs, rar, refShr(ra, rs, rar), n % 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
      $finish;
   end

endmodule
